flasher_monitor: RTL and testbench

FLASHER_MONITOR -- requirements
Module: flasher_monitor

---
 rtl/flasher_monitor.sv | 137 +++++++++++++
 tb/tb_flasher_monitor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/flasher_monitor.sv
// Watches a 16-lamp thermometer bus and tracks its level, direction, reversals and errors.
// Latency: one clock from lamps to every output; all outputs are registered.
// Backpressure: none; lamps is sampled every cycle and the monitor never stalls the flasher.
module flasher_monitor (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] lamps,
   input  logic        err_clr,
   output logic [4:0]  level,
   output logic [1:0]  dir,
   output logic [4:0]  peak,
   output logic [7:0]  bounce_cnt,
   output logic        cycle_done,
   output logic        abort,
   output logic        err_shape,
   output logic        err_step
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  level_q, level_d;
   logic [4:0]  peak_q, peak_d;
   logic [7:0]  bounce_q, bounce_d;
   logic        cycle_done_q, cycle_done_d;
   logic        abort_q, abort_d;
   logic        err_shape_q, err_shape_d;
   logic        err_step_q, err_step_d;

   logic [4:0]  n;
   logic        legal;
   logic        up1, dn1;
   logic        shape_hit, step_hit, rev;

   // Decode the lamp bus: lit-lamp count and thermometer-code legality (x & (x+1) == 0).
   always_comb begin
      n = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n = n + 5'(lamps[i]);
      end
      legal = (({1'b0, lamps} & ({1'b0, lamps} + 17'd1)) == 17'd0);
      up1   = ({1'b0, n} == ({1'b0, level_q} + 6'd1));
      dn1   = (({1'b0, n} + 6'd1) == {1'b0, level_q});
   end

   // Next-state and output logic: compare the decoded count against the held level.
   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      peak_d       = peak_q;
      bounce_d     = bounce_q;
      cycle_done_d = 1'b0;
      abort_d      = 1'b0;
      shape_hit    = 1'b0;
      step_hit     = 1'b0;
      rev          = 1'b0;

      if (!legal) begin
         // Malformed bus: flag it and freeze the tracked state.
         shape_hit = 1'b1;
      end else begin
         level_d = n;
         if (n == 5'd0) begin
            state_d = IDLE;
            if (level_q >= 5'd2) begin
               abort_d = 1'b1;
            end else if (level_q == 5'd1) begin
               if (state_q == DOWN) begin
                  cycle_done_d = 1'b1;
               end else if (state_q == UP) begin
                  rev = 1'b1;
               end
            end
         end else if (up1) begin
            state_d = UP;
            if (state_q == DOWN) begin
               rev = 1'b1;
            end
         end else if (dn1) begin
            state_d = DOWN;
            if (state_q == UP) begin
               rev = 1'b1;
            end
         end else if (n != level_q) begin
            // Jump of two or more: resynchronise direction, leave peak/bounce alone.
            step_hit = 1'b1;
            state_d  = (n > level_q) ? UP : DOWN;
         end
      end

      if (rev) begin
         peak_d   = level_q;
         bounce_d = (bounce_q == 8'hFF) ? bounce_q : bounce_q + 8'd1;
      end

      // A fresh error in the same cycle as a clear must leave the flag set.
      err_shape_d = shape_hit | (err_shape_q & ~err_clr);
      err_step_d  = step_hit  | (err_step_q  & ~err_clr);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         level_q      <= 5'd0;
         peak_q       <= 5'd0;
         bounce_q     <= 8'd0;
         cycle_done_q <= 1'b0;
         abort_q      <= 1'b0;
         err_shape_q  <= 1'b0;
         err_step_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         peak_q       <= peak_d;
         bounce_q     <= bounce_d;
         cycle_done_q <= cycle_done_d;
         abort_q      <= abort_d;
         err_shape_q  <= err_shape_d;
         err_step_q   <= err_step_d;
      end
   end

   assign level      = level_q;
   assign dir        = state_q;
   assign peak       = peak_q;
   assign bounce_cnt = bounce_q;
   assign cycle_done = cycle_done_q;
   assign abort      = abort_q;
   assign err_shape  = err_shape_q;
   assign err_step   = err_step_q;

endmodule

// File: tb/tb_flasher_monitor.sv
// Bench for flasher_monitor: directed lamp sequences with hand-derived expected outputs.
// Latency: expected values are queued at drive time and checked one edge later.
// Backpressure: none; one vector per clock, monitor pops one entry per edge.
module tb_flasher_monitor;

   logic        clk;
   logic        reset;
   logic [15:0] lamps;
   logic        err_clr;
   logic [4:0]  level;
   logic [1:0]  dir;
   logic [4:0]  peak;
   logic [7:0]  bounce_cnt;
   logic        cycle_done;
   logic        abort;
   logic        err_shape;
   logic        err_step;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0] lv;
      logic [1:0] d;
      logic [4:0] pk;
      logic [7:0] bc;
      logic       cd;
      logic       ab;
      logic       es;
      logic       est;
   } exp_t;

   exp_t  expq[$];
   string nameq[$];

   flasher_monitor dut (
      .clk        (clk),
      .reset      (reset),
      .lamps      (lamps),
      .err_clr    (err_clr),
      .level      (level),
      .dir        (dir),
      .peak       (peak),
      .bounce_cnt (bounce_cnt),
      .cycle_done (cycle_done),
      .abort      (abort),
      .err_shape  (err_shape),
      .err_step   (err_step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string nm, input string fld, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, expv);
      end
   endfunction

   function automatic exp_t mk(input int lv, input int d, input int pk, input int bc,
                               input bit cd, input bit ab, input bit es, input bit est);
      exp_t e;
      e.lv  = 5'(lv);
      e.d   = 2'(d);
      e.pk  = 5'(pk);
      e.bc  = 8'(bc);
      e.cd  = cd;
      e.ab  = ab;
      e.es  = es;
      e.est = est;
      return e;
   endfunction

   function automatic logic [15:0] therm(input int k);
      logic [16:0] t;
      t = (17'd1 << k) - 17'd1;
      return t[15:0];
   endfunction

   function automatic void chk_reset_vals(input string nm);
      chk(nm, "level", level, 0);
      chk(nm, "dir", dir, 0);
      chk(nm, "peak", peak, 0);
      chk(nm, "bounce_cnt", bounce_cnt, 0);
      chk(nm, "cycle_done", cycle_done, 0);
      chk(nm, "abort", abort, 0);
      chk(nm, "err_shape", err_shape, 0);
      chk(nm, "err_step", err_step, 0);
   endfunction

   // Stimulus side: apply one vector and queue what the next edge must produce.
   task automatic drv(input logic [15:0] l, input logic clr, input exp_t e, input string nm);
      @(negedge clk);
      lamps   = l;
      err_clr = clr;
      expq.push_back(e);
      nameq.push_back(nm);
   endtask

   // Asynchronous reset pulse placed between clock edges; checked without any edge.
   task automatic do_reset(input string nm);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals({nm, "_async"});
      lamps   = 16'hA5A5;
      err_clr = 1'b1;
      #19;
      chk_reset_vals({nm, "_hold"});
      @(negedge clk);
      lamps   = 16'h0000;
      err_clr = 1'b0;
      reset   = 1'b1;
   endtask

   // Monitor side: on every active edge outside reset, pop and compare.
   always @(posedge clk) begin
      exp_t  e;
      string nm;
      #1;
      if (reset && expq.size() > 0) begin
         e  = expq.pop_front();
         nm = nameq.pop_front();
         chk(nm, "level", level, e.lv);
         chk(nm, "dir", dir, e.d);
         chk(nm, "peak", peak, e.pk);
         chk(nm, "bounce_cnt", bounce_cnt, e.bc);
         chk(nm, "cycle_done", cycle_done, e.cd);
         chk(nm, "abort", abort, e.ab);
         chk(nm, "err_shape", err_shape, e.es);
         chk(nm, "err_step", err_step, e.est);
      end
   end

   initial begin
      reset   = 1'b0;
      lamps   = 16'h0000;
      err_clr = 1'b0;
      #12;
      chk_reset_vals("por");
      @(negedge clk);
      reset = 1'b1;

      // Full sweep up, stall at top, back down, cycle_done one edge after zero.
      drv(16'h0000, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), "sweep_zero");
      for (int i = 1; i <= 16; i++)
         drv(therm(i), 1'b0, mk(i, 1, 0, 0, 0, 0, 0, 0), "sweep_up");
      drv(16'hFFFF, 1'b0, mk(16, 1, 0, 0, 0, 0, 0, 0), "sweep_top_stall");
      for (int i = 15; i >= 0; i--)
         drv(therm(i), 1'b0, mk(i, (i == 0) ? 0 : 2, 16, 1, i == 0, 0, 0, 0), "sweep_down");
      drv(16'h0000, 1'b0, mk(0, 0, 16, 1, 0, 0, 0, 0), "sweep_idle_after");

      // Kickback: up to 5, down to 3, up to 10; then abort from 8.
      do_reset("rst_kick");
      for (int i = 1; i <= 5; i++)
         drv(therm(i), 1'b0, mk(i, 1, 0, 0, 0, 0, 0, 0), "kick_up1");
      drv(therm(4), 1'b0, mk(4, 2, 5, 1, 0, 0, 0, 0), "kick_rev1");
      drv(therm(3), 1'b0, mk(3, 2, 5, 1, 0, 0, 0, 0), "kick_down");
      drv(therm(4), 1'b0, mk(4, 1, 3, 2, 0, 0, 0, 0), "kick_rev2");
      for (int i = 5; i <= 10; i++)
         drv(therm(i), 1'b0, mk(i, 1, 3, 2, 0, 0, 0, 0), "kick_up2");
      drv(therm(9), 1'b0, mk(9, 2, 10, 3, 0, 0, 0, 0), "abort_rev");
      drv(16'h00FF, 1'b0, mk(8, 2, 10, 3, 0, 0, 0, 0), "abort_at8");
      drv(16'h0000, 1'b0, mk(0, 0, 10, 3, 0, 1, 0, 0), "abort_pulse");
      drv(16'h0000, 1'b0, mk(0, 0, 10, 3, 0, 0, 0, 0), "abort_single");

      // Illegal shapes and err_clr priority.
      do_reset("rst_shape");
      for (int i = 1; i <= 3; i++)
         drv(therm(i), 1'b0, mk(i, 1, 0, 0, 0, 0, 0, 0), "shape_up");
      drv(16'h0005, 1'b0, mk(3, 1, 0, 0, 0, 0, 1, 0), "shape_bad");
      drv(16'h0007, 1'b1, mk(3, 1, 0, 0, 0, 0, 0, 0), "shape_clr");
      drv(16'h0009, 1'b1, mk(3, 1, 0, 0, 0, 0, 1, 0), "shape_clr_vs_new");
      drv(16'h0007, 1'b0, mk(3, 1, 0, 0, 0, 0, 1, 0), "shape_sticky");
      drv(16'h0007, 1'b1, mk(3, 1, 0, 0, 0, 0, 0, 0), "shape_clr2");

      // Step errors in both directions and against a simultaneous clear.
      do_reset("rst_step");
      drv(therm(1), 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0), "step_l1");
      drv(therm(2), 1'b0, mk(2, 1, 0, 0, 0, 0, 0, 0), "step_l2");
      drv(16'h001F, 1'b0, mk(5, 1, 0, 0, 0, 0, 0, 1), "step_jump_up");
      drv(16'h0003, 1'b0, mk(2, 2, 0, 0, 0, 0, 0, 1), "step_jump_down");
      drv(16'h00FF, 1'b1, mk(8, 1, 0, 0, 0, 0, 0, 1), "step_clr_vs_new");
      drv(16'h00FF, 1'b1, mk(8, 1, 0, 0, 0, 0, 0, 0), "step_clr");
      drv(16'h0000, 1'b0, mk(0, 0, 0, 0, 0, 1, 0, 0), "step_abort_noerr");
      drv(16'h0007, 1'b0, mk(3, 1, 0, 0, 0, 0, 0, 1), "step_from_idle");

      // Bounce counter saturation: oscillate between levels 1 and 2.
      do_reset("rst_sat");
      drv(therm(1), 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0), "sat_l1");
      drv(therm(2), 1'b0, mk(2, 1, 0, 0, 0, 0, 0, 0), "sat_l2");
      for (int k = 1; k <= 260; k++) begin
         if (k % 2 == 1)
            drv(therm(1), 1'b0, mk(1, 2, 2, (k > 255) ? 255 : k, 0, 0, 0, 0), "sat_osc");
         else
            drv(therm(2), 1'b0, mk(2, 1, 1, (k > 255) ? 255 : k, 0, 0, 0, 0), "sat_osc");
      end

      // Reset mid-run at level 10 heading down; history must be gone afterwards.
      do_reset("rst_mid_pre");
      for (int i = 1; i <= 11; i++)
         drv(therm(i), 1'b0, mk(i, 1, 0, 0, 0, 0, 0, 0), "mid_up");
      drv(therm(10), 1'b0, mk(10, 2, 11, 1, 0, 0, 0, 0), "mid_down");
      do_reset("rst_mid");
      drv(therm(1), 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0), "mid_after");

      // Drain: every queued expectation must have been consumed.
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d expected=0 pending entries", expq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
